// File: rtl/serial_pkg.sv
// Shared serial-link definitions.
// Used by the transmit and receive sides.
package serial_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_e;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter.
// Holding register feeds a shift register; one bit per sr_clk.
module piso_tx
    import serial_pkg::*;
#(
    parameter int STOP_BITS = 1
) (
    input  logic                 sr_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 data_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic       STOP_LAST = (STOP_BITS == 2);
    localparam logic [2:0] CNT_LAST  = 3'(DATA_BITS - 1);

    ser_state_e           state, state_n;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [2:0]           bit_cnt, cnt_n;
    logic                 stop_cnt, stop_n;
    logic                 line_n;
    logic                 take;

    assign ready   = ~hold_full;
    assign busy    = (state != IDLE);
    assign tx_done = (state == STOP) && (stop_cnt == STOP_LAST);

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
        stop_n  = stop_cnt;
        line_n  = IDLE_LEVEL;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n = START;
                    shift_n = hold_reg;
                    line_n  = 1'b0;
                    take    = 1'b1;
                end
            end
            START: begin
                state_n = DATA;
                cnt_n   = 3'd0;
                line_n  = shift_reg[0];
                shift_n = shift_reg >> 1;
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    state_n = STOP;
                    stop_n  = 1'b0;
                    line_n  = IDLE_LEVEL;
                end else begin
                    cnt_n   = bit_cnt + 3'd1;
                    line_n  = shift_reg[0];
                    shift_n = shift_reg >> 1;
                end
            end
            STOP: begin
                if (stop_cnt == STOP_LAST) begin
                    cnt_n = 3'd0;
                    // a waiting byte starts with no idle gap
                    if (hold_full) begin
                        state_n = START;
                        shift_n = hold_reg;
                        line_n  = 1'b0;
                        take    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    stop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sr_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            data_out  <= IDLE_LEVEL;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= cnt_n;
            stop_cnt  <= stop_n;
            data_out  <= line_n;
        end
    end

    always_ff @(posedge sr_clk or posedge reset) begin
        if (reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (take) begin
            hold_full <= 1'b0;
        end else if (load && !hold_full) begin
            hold_reg  <= data_in;
            hold_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx with an expected-bit scoreboard.
// Two instances cover one and two stop bits.
module tb_piso_tx;

    typedef struct {
        logic line;
        logic done;
        logic busy;
    } exp_t;

    logic       sr_clk;
    logic       reset;
    logic [7:0] data1, data2;
    logic       load1, load2;
    logic       ready1, ready2;
    logic       out1, out2;
    logic       busy1, busy2;
    logic       done1, done2;
    logic [9:0] rx;

    exp_t q1[$];
    exp_t q2[$];

    int compared = 0;
    int mismatched = 0;

    piso_tx #(.STOP_BITS(1)) dut1 (
        .sr_clk  (sr_clk),
        .reset   (reset),
        .data_in (data1),
        .load    (load1),
        .ready   (ready1),
        .data_out(out1),
        .busy    (busy1),
        .tx_done (done1)
    );

    piso_tx #(.STOP_BITS(2)) dut2 (
        .sr_clk  (sr_clk),
        .reset   (reset),
        .data_in (data2),
        .load    (load2),
        .ready   (ready2),
        .data_out(out2),
        .busy    (busy2),
        .tx_done (done2)
    );

    initial sr_clk = 1'b0;
    always #5 sr_clk = ~sr_clk;

    // loopback receiver: LSB-first 10-bit shift register
    always @(posedge sr_clk) rx <= {out1, rx[9:1]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic timeout(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    function automatic exp_t mk(input logic l, input logic d, input logic b);
        exp_t e;
        e.line = l;
        e.done = d;
        e.busy = b;
        return e;
    endfunction

    task automatic push1(input logic [7:0] b);
        if (q1.size() == 0) q1.push_back(mk(1'b1, 1'b0, 1'b0));
        q1.push_back(mk(1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) q1.push_back(mk(b[i], 1'b0, 1'b1));
        q1.push_back(mk(1'b1, 1'b1, 1'b1));
    endtask

    task automatic push2(input logic [7:0] b);
        if (q2.size() == 0) q2.push_back(mk(1'b1, 1'b0, 1'b0));
        q2.push_back(mk(1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) q2.push_back(mk(b[i], 1'b0, 1'b1));
        q2.push_back(mk(1'b1, 1'b0, 1'b1));
        q2.push_back(mk(1'b1, 1'b1, 1'b1));
    endtask

    task automatic tick();
        exp_t e1, e2;
        @(posedge sr_clk);
        #1;
        e1 = (q1.size() > 0) ? q1.pop_front() : mk(1'b1, 1'b0, 1'b0);
        e2 = (q2.size() > 0) ? q2.pop_front() : mk(1'b1, 1'b0, 1'b0);
        chk("d1.data_out", 32'(out1), 32'(e1.line));
        chk("d1.tx_done", 32'(done1), 32'(e1.done));
        chk("d1.busy", 32'(busy1), 32'(e1.busy));
        chk("d2.data_out", 32'(out2), 32'(e2.line));
        chk("d2.tx_done", 32'(done2), 32'(e2.done));
        chk("d2.busy", 32'(busy2), 32'(e2.busy));
    endtask

    task automatic send1(input logic [7:0] b);
        data1 = b;
        load1 = 1'b1;
        push1(b);
        tick();
        load1 = 1'b0;
        data1 = ~b;
    endtask

    task automatic send2(input logic [7:0] b);
        data2 = b;
        load2 = 1'b1;
        push2(b);
        tick();
        load2 = 1'b0;
        data2 = ~b;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 40) begin
            tick();
            n++;
        end
        if (q1.size() > 0 || q2.size() > 0) begin
            timeout("drain");
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic wait_ready1();
        int n = 0;
        while (!ready1 && n < 20) begin
            tick();
            n++;
        end
        if (!ready1) timeout("wait_ready1");
    endtask

    task automatic loopback(input logic [7:0] b);
        send1(b);
        drain();
        tick();
        chk("rx.start", 32'(rx[0]), 32'(1'b0));
        chk("rx.byte", 32'(rx[8:1]), 32'(b));
        chk("rx.stop", 32'(rx[9]), 32'(1'b1));
    endtask

    initial begin
        reset = 1'b1;
        load1 = 1'b0;
        load2 = 1'b0;
        data1 = 8'h00;
        data2 = 8'h00;
        repeat (2) @(posedge sr_clk);
        #1;
        chk("rst.data_out", 32'(out1), 32'(1'b1));
        chk("rst.busy", 32'(busy1), 32'(1'b0));
        chk("rst.tx_done", 32'(done1), 32'(1'b0));
        chk("rst.ready", 32'(ready1), 32'(1'b1));
        chk("rst.ready2", 32'(ready2), 32'(1'b1));
        reset = 1'b0;
        repeat (2) tick();

        // 0xA5 from idle, with loopback
        send1(8'hA5);
        chk("a5.ready_low", 32'(ready1), 32'(1'b0));
        tick();
        chk("a5.ready_back", 32'(ready1), 32'(1'b1));
        drain();
        tick();
        chk("a5.rx", 32'(rx[8:1]), 32'(8'hA5));

        loopback(8'h00);
        loopback(8'hFF);
        loopback(8'hA5);

        // back-to-back frames
        send1(8'h3C);
        wait_ready1();
        send1(8'hFF);
        drain();
        repeat (2) tick();

        // load while not ready is ignored
        send1(8'h96);
        chk("ign.ready_low", 32'(ready1), 32'(1'b0));
        data1 = 8'h00;
        load1 = 1'b1;
        tick();
        load1 = 1'b0;
        chk("ign.ready_back", 32'(ready1), 32'(1'b1));
        drain();
        repeat (12) tick();

        // two stop bits
        send2(8'h81);
        drain();
        repeat (2) tick();

        // reset mid-frame at D3 with a byte held
        send1(8'h55);
        wait_ready1();
        send1(8'hC3);
        chk("rst2.held", 32'(ready1), 32'(1'b0));
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("rst2.data_out", 32'(out1), 32'(1'b1));
        chk("rst2.busy", 32'(busy1), 32'(1'b0));
        chk("rst2.ready", 32'(ready1), 32'(1'b1));
        chk("rst2.tx_done", 32'(done1), 32'(1'b0));
        q1.delete();
        tick();
        reset = 1'b0;
        repeat (14) tick();
        chk("rst2.ready_after", 32'(ready1), 32'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
